// File: rtl/sw_sel_seq.sv
// -----------------------------------------------------------------------------
// sw_sel_seq -- LVDA switch-selector command sequencer
//
// Accepts one switch-selector command (stage select + 8-bit address) at a time
// and walks the 15-bit switch-selector register through:
//   load -> feedback verify -> (complemented retry) -> READ -> register reset.
// The block owns the register's load (SSR_LOAD) and reset (SSR_CLR) strobes.
//
// Parameters (each constrained to 1..255):
//   VERIFY_CYC  cycles from a load strobe to the feedback sample
//   READ_CYC    cycles the READ bit is held in the register
//   RESET_CYC   cycles from the register-reset strobe to completion,
//               including the strobe cycle
//
// Ports:
//   SIM_CLK    in   system clock, rising edge
//   SIM_RST    in   synchronous active-high reset
//   CMD_REQ    in   command request (level, sampled only when idle)
//   CMD_STAGE  in   [3:0] stage select, captured at acceptance
//   CMD_ADDR   in   [7:0] switch address, captured at acceptance
//   CMD_ABORT  in   abort the command in progress
//   FB_ADDR    in   [7:0] selector feedback (complement of received address)
//   CMD_ACK    out  one-cycle pulse: request accepted
//   BUSY       out  high from the ACK cycle until the cycle before DONE
//   DONE       out  one-cycle pulse: sequence finished
//   ERR        out  one-cycle pulse with DONE on double verify failure/abort
//   SSR_LOAD   out  one-cycle register load strobe
//   SSR_DATA   out  [14:0] register image {0, COMPL, READ, stage, addr}
//   SSR_CLR    out  one-cycle register reset strobe (held while in reset)
// -----------------------------------------------------------------------------
module sw_sel_seq #(
  parameter int VERIFY_CYC = 4,
  parameter int READ_CYC   = 8,
  parameter int RESET_CYC  = 2
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        CMD_REQ,
  input  logic [3:0]  CMD_STAGE,
  input  logic [7:0]  CMD_ADDR,
  input  logic        CMD_ABORT,
  input  logic [7:0]  FB_ADDR,
  output logic        CMD_ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        SSR_LOAD,
  output logic [14:0] SSR_DATA,
  output logic        SSR_CLR
);

  // Down-counter reload values. VERIFY counts V..0 so the feedback sample
  // lands on the edge ending the V-th cycle after the load strobe; READ and
  // the reset wait include their first (strobe) cycle, hence the -1.
  localparam logic [7:0] VERIFY_LD = 8'(VERIFY_CYC);
  localparam logic [7:0] READ_LD   = 8'(READ_CYC - 1);
  localparam logic [7:0] RESET_LD  = 8'(RESET_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERIFY = 3'd1,
    READ   = 3'd2,
    CLEAR  = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Register image layout: {1'b0, COMPL, READ, stage[3:0], addr_field[7:0]}.
  function automatic logic [14:0] ssr_image(input logic [3:0] stage,
                                            input logic [7:0] addr_field,
                                            input logic       read_bit,
                                            input logic       compl_bit);
    return {1'b0, compl_bit, read_bit, stage, addr_field};
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        retry_q, retry_d;       // a complemented reload follows CLEAR
  logic        on_retry_q, on_retry_d; // current attempt is the retry
  logic        fail_q, fail_d;         // report ERR with DONE

  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        load_q, load_d;
  logic        clr_q, clr_d;
  logic [14:0] data_q, data_d;

  logic [3:0]  stage_q;
  logic [7:0]  addr_q;
  logic        cap_en;
  logic        fb_match;
  logic        retry_eff;

  // The selector echoes the complement of whatever address field it holds,
  // so the same compare works for both the true and the complemented load.
  assign fb_match = (FB_ADDR == ~data_q[7:0]);

  // ---------------------------------------------------------------------------
  // Next-state and registered-output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    on_retry_d = on_retry_q;
    fail_d     = fail_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    load_d     = 1'b0;
    clr_d      = 1'b0;
    data_d     = data_q;
    cap_en     = 1'b0;
    retry_eff  = retry_q;

    unique case (state_q)
      IDLE: begin
        if (CMD_REQ) begin
          cap_en     = 1'b1;
          ack_d      = 1'b1;
          load_d     = 1'b1;
          data_d     = ssr_image(CMD_STAGE, CMD_ADDR, 1'b0, 1'b0);
          cnt_d      = VERIFY_LD;
          retry_d    = 1'b0;
          on_retry_d = 1'b0;
          fail_d     = 1'b0;
          state_d    = VERIFY;
        end
      end

      VERIFY: begin
        if (CMD_ABORT) begin
          retry_d = 1'b0;
          fail_d  = 1'b1;
          clr_d   = 1'b1;
          data_d  = '0;
          cnt_d   = RESET_LD;
          state_d = CLEAR;
        end else if (cnt_q == 8'd0) begin
          if (fb_match) begin
            load_d     = 1'b1;
            data_d[12] = 1'b1;
            cnt_d      = READ_LD;
            state_d    = READ;
          end else begin
            // First mismatch schedules a complemented reload; a mismatch on
            // that reload ends the command with an error.
            retry_d = ~on_retry_q;
            fail_d  = on_retry_q;
            clr_d   = 1'b1;
            data_d  = '0;
            cnt_d   = RESET_LD;
            state_d = CLEAR;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      READ: begin
        if (CMD_ABORT || cnt_q == 8'd0) begin
          fail_d  = fail_q | CMD_ABORT;
          retry_d = 1'b0;
          clr_d   = 1'b1;
          data_d  = '0;
          cnt_d   = RESET_LD;
          state_d = CLEAR;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      // Reset wait that may still lead to a reload. An abort here cancels the
      // reload and turns the remainder into the final wait.
      CLEAR: begin
        if (retry_q && CMD_ABORT) begin
          retry_eff = 1'b0;
          retry_d   = 1'b0;
          fail_d    = 1'b1;
        end
        if (cnt_q == 8'd0) begin
          if (retry_eff) begin
            load_d     = 1'b1;
            data_d     = ssr_image(stage_q, ~addr_q, 1'b0, 1'b1);
            cnt_d      = VERIFY_LD;
            retry_d    = 1'b0;
            on_retry_d = 1'b1;
            state_d    = VERIFY;
          end else begin
            done_d  = 1'b1;
            err_d   = fail_d;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (!retry_eff) begin
            state_d = FINISH;
          end
        end
      end

      // Final reset wait: nothing but the countdown to DONE.
      FINISH: begin
        if (cnt_q == 8'd0) begin
          done_d  = 1'b1;
          err_d   = fail_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      retry_q    <= 1'b0;
      on_retry_q <= 1'b0;
      fail_q     <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      load_q     <= 1'b0;
      clr_q      <= 1'b1;   // drop the relays while held in reset
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      on_retry_q <= on_retry_d;
      fail_q     <= fail_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      load_q     <= load_d;
      clr_q      <= clr_d;
      data_q     <= data_d;
    end
  end

  // Command capture: only consulted for the complemented reload.
  always_ff @(posedge SIM_CLK) begin
    if (cap_en) begin
      stage_q <= CMD_STAGE;
      addr_q  <= CMD_ADDR;
    end
  end

  assign CMD_ACK  = ack_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign SSR_LOAD = load_q;
  assign SSR_DATA = data_q;
  assign SSR_CLR  = clr_q;

endmodule

// File: tb/tb_sw_sel_seq.sv
// -----------------------------------------------------------------------------
// tb_sw_sel_seq -- self-checking bench for sw_sel_seq.
// Expected outputs come from a timeline model: the event cycles (reload, READ
// strobe, register reset, DONE) are computed in closed form from the command,
// the feedback values and the timing parameters, then expanded per cycle.
// dut0 uses the default timing, dut1 uses VERIFY=READ=RESET=1.
// -----------------------------------------------------------------------------
module tb_sw_sel_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [3:0]  cmd_stage;
  logic [7:0]  cmd_addr;
  logic        cmd_abort;
  logic [7:0]  fb;

  logic        ack0, busy0, done0, err0, load0, clr0;
  logic [14:0] data0;
  logic        ack1, busy1, done1, err1, load1, clr1;
  logic [14:0] data1;

  int n_checks = 0;
  int n_err    = 0;

  // per-cycle expected vector {ack, busy, done, err, load, clr, data[14:0]}
  logic [20:0] exp_q [0:255];
  int          exp_done;
  int          exp_clr1;
  int          exp_k;

  logic [3:0]  r_st;
  logic [7:0]  r_ad, r_f1, r_f2;
  int          r_ab, r_gap;
  bit          r_hold;

  always #5 clk = ~clk;

  sw_sel_seq #(.VERIFY_CYC(4), .READ_CYC(8), .RESET_CYC(2)) dut0 (
    .SIM_CLK(clk), .SIM_RST(rst), .CMD_REQ(req[0]), .CMD_STAGE(cmd_stage),
    .CMD_ADDR(cmd_addr), .CMD_ABORT(cmd_abort), .FB_ADDR(fb),
    .CMD_ACK(ack0), .BUSY(busy0), .DONE(done0), .ERR(err0),
    .SSR_LOAD(load0), .SSR_DATA(data0), .SSR_CLR(clr0));

  sw_sel_seq #(.VERIFY_CYC(1), .READ_CYC(1), .RESET_CYC(1)) dut1 (
    .SIM_CLK(clk), .SIM_RST(rst), .CMD_REQ(req[1]), .CMD_STAGE(cmd_stage),
    .CMD_ADDR(cmd_addr), .CMD_ABORT(cmd_abort), .FB_ADDR(fb),
    .CMD_ACK(ack1), .BUSY(busy1), .DONE(done1), .ERR(err1),
    .SSR_LOAD(load1), .SSR_DATA(data1), .SSR_CLR(clr1));

  function automatic logic [20:0] get_obs(input int sel);
    if (sel == 1) return {ack1, busy1, done1, err1, load1, clr1, data1};
    return {ack0, busy0, done0, err0, load0, clr0, data0};
  endfunction

  task automatic check(input int sel, input logic [20:0] expv, input string tag);
    logic [20:0] obs;
    obs = get_obs(sel);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, sel, obs, expv);
    end
  endtask

  // Build the expected timeline. ab: -1 no abort, -2 random abort cycle,
  // >=0 abort sampled at the end of that cycle.
  task automatic plan(input int v, input int r, input int t,
                      input logic [3:0] st, input logic [7:0] ad,
                      input logic [7:0] f1, input logic [7:0] f2, input int ab);
    int read_at, c1, reload, clr_at, done, n1, n2, pick, k;
    bit fail;
    logic [14:0] img;
    read_at = -1; c1 = -1; reload = -1; fail = 1'b0;
    if (f1 == ~ad) begin
      read_at = v + 1;
      clr_at  = v + r + 1;
    end else begin
      c1     = v + 1;
      reload = v + 1 + t;
      if (f2 == ad) begin
        read_at = reload + v + 1;
        clr_at  = read_at + r;
      end else begin
        clr_at = reload + v + 1;
        fail   = 1'b1;
      end
    end
    k = ab;
    if (ab == -2) begin
      // abort only while verifying or reading
      n1   = (c1 >= 0) ? c1 : clr_at;
      n2   = (c1 >= 0) ? (clr_at - reload) : 0;
      pick = $urandom_range(0, n1 + n2 - 1);
      k    = (pick < n1) ? pick : reload + (pick - n1);
    end
    if (k >= 0) begin
      if (read_at > k) read_at = -1;
      if (c1 > k) c1 = -1;
      if (reload > k) reload = -1;
      clr_at = k + 1;
      fail   = 1'b1;
    end
    done = clr_at + t;
    img  = '0;
    for (int c = 0; c <= done; c++) begin
      if (c == 0)       img = {3'b000, st, ad};
      if (c == read_at) img = img | 15'h1000;
      if (c == c1 || c == clr_at) img = '0;
      if (c == reload)  img = {3'b010, st, ~ad};
      exp_q[c] = {c == 0, c < done, c == done, (c == done) && fail,
                  (c == 0) || (c == read_at) || (c == reload),
                  (c == c1) || (c == clr_at), img};
    end
    exp_done = done;
    exp_clr1 = c1;
    exp_k    = k;
  endtask

  // Entered in the cycle the request is presented; returns after checking the
  // DONE cycle (or the cycle after a mid-sequence reset when rst_k >= 0).
  task automatic run_cmd(input int sel, input logic [3:0] st, input logic [7:0] ad,
                         input logic [7:0] f1, input logic [7:0] f2, input int ab,
                         input bit hold, input int rst_k);
    int v, r, t;
    v = (sel == 1) ? 1 : 4;
    r = (sel == 1) ? 1 : 8;
    t = (sel == 1) ? 1 : 2;
    plan(v, r, t, st, ad, f1, f2, ab);
    req       = 2'b00;
    req[sel]  = 1'b1;
    cmd_stage = st;
    cmd_addr  = ad;
    fb        = f1;
    cmd_abort = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c <= exp_done; c++) begin
      check(sel, exp_q[c], $sformatf("cyc%0d", c));
      if (c == exp_done) break;
      req[sel] = hold;
      if (hold) begin
        cmd_stage = 4'($urandom);
        cmd_addr  = 8'($urandom);
      end
      fb        = (exp_clr1 >= 0 && c >= exp_clr1) ? f2 : f1;
      cmd_abort = (c == exp_k);
      if (c == rst_k) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check(sel, 21'h008000, "reset_mid");
        rst       = 1'b0;
        req       = 2'b00;
        cmd_abort = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    cmd_abort = 1'b0;
  endtask

  task automatic idle(input int n);
    req       = 2'b00;
    cmd_abort = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check(0, 21'h0, "idle");
      check(1, 21'h0, "idle");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = 2'b00; cmd_stage = '0; cmd_addr = '0;
    cmd_abort = 1'b0; fb = '0;
    repeat (2) @(posedge clk);
    #1;
    check(0, 21'h008000, "reset");
    check(1, 21'h008000, "reset");
    rst = 1'b0;
    idle(2);

    // success on first try
    run_cmd(0, 4'h3, 8'h5A, 8'hA5, 8'h00, -1, 1'b0, -1);
    idle(1);
    // complemented retry succeeds
    run_cmd(0, 4'h3, 8'h5A, 8'h00, 8'h5A, -1, 1'b0, -1);
    idle(1);
    // feedback stuck: retry fails
    run_cmd(0, 4'h3, 8'h5A, 8'h00, 8'h00, -1, 1'b0, -1);
    idle(1);
    // abort in READ with a second request held while busy, then back-to-back
    run_cmd(0, 4'h3, 8'h5A, 8'hA5, 8'h00, 7, 1'b1, -1);
    run_cmd(0, 4'hC, 8'h81, 8'h7E, 8'h00, -1, 1'b0, -1);
    idle(1);
    // reset mid-sequence, then a fresh request
    run_cmd(0, 4'h3, 8'h5A, 8'hA5, 8'h00, -1, 1'b0, 6);
    idle(3);
    run_cmd(0, 4'h1, 8'h0F, 8'hF0, 8'h00, -1, 1'b0, -1);
    idle(1);
    // minimum timing parameters
    run_cmd(1, 4'h3, 8'h5A, 8'hA5, 8'h00, -1, 1'b0, -1);
    idle(1);
    run_cmd(1, 4'h6, 8'hC3, 8'h11, 8'hC3, -1, 1'b0, -1);
    idle(1);

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      r_st = 4'($urandom);
      r_ad = 8'($urandom);
      r_f1 = 8'($urandom);
      r_f2 = 8'($urandom);
      case ($urandom_range(0, 3))
        0: r_f1 = ~r_ad;
        1: r_f2 = r_ad;
        default: ;
      endcase
      r_ab   = ($urandom_range(0, 3) == 0) ? -2 : -1;
      r_hold = 1'($urandom_range(0, 1));
      run_cmd(i % 5 == 4 ? 1 : 0, r_st, r_ad, r_f1, r_f2, r_ab, r_hold, -1);
      r_gap = $urandom_range(0, 2);
      if (r_gap > 0) idle(r_gap);
    end
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sw_sel_seq.md
# sw_sel_seq

Switch-selector command sequencer for the LVDA. It takes one switch-selector command at a time (stage select plus 8-bit address) from the processor-interface side. It then drives the 15-bit switch-selector register through the full sequence: load, feedback verify, complement retry, READ, register reset. It sits between the I/O decode logic and the switch-selector register bank, and it owns the register's load and reset strobes.

## Interface
- VERIFY_CYC, 4: cycles from a load strobe to the feedback sample (min 1).
- READ_CYC, 8: cycles the READ bit is held in the register (min 1).
- RESET_CYC, 2: cycles from the register-reset strobe to completion, including the strobe cycle (min 1).
- SIM_CLK  in  1  system clock; all state changes on its rising edge.
- SIM_RST  in  1  reset; synchronous, active-high.
- CMD_REQ  in  1  command request; level, sampled only in IDLE.
- CMD_STAGE  in  4  stage select, captured at acceptance.
- CMD_ADDR  in  8  switch address, captured at acceptance.
- CMD_ABORT  in  1  abort the current command; ignored in IDLE and in the final reset wait.
- FB_ADDR  in  8  switch-selector feedback lines; the selector returns the complement of the address it received.
- CMD_ACK  out  1  one-cycle pulse: request accepted.
- BUSY  out  1  high from the ACK cycle until the cycle before DONE.
- DONE  out  1  one-cycle pulse: sequence finished (success or failure).
- ERR  out  1  one-cycle pulse coincident with DONE when verification failed twice or the command was aborted.
- SSR_LOAD  out  1  one-cycle load strobe to the register.
- SSR_DATA  out  15  register image.
  - [7:0] address field.
  - [11:8] stage.
  - [12] READ.
  - [13] COMPL (address field is complemented).
  - [14] always 0.
- SSR_CLR  out  1  one-cycle register-reset strobe.

## Operation
- States: IDLE, VERIFY, READ, CLEAR, FINISH.
- Reset values: SSR_CLR = 1 while SIM_RST is high, so the relays drop. Every other output is 0 and the state is IDLE. Reset mid-sequence abandons the command with no DONE.
- **IDLE, CMD_REQ = 1:**
  - Capture the stage and address.
  - Next cycle: CMD_ACK = 1, BUSY = 1, SSR_LOAD = 1, SSR_DATA = {0, 0, 0, stage, addr}. Go to VERIFY.
- **VERIFY:** SSR_DATA holds. On the edge ending the VERIFY_CYC-th cycle after the load strobe, sample FB_ADDR.
  - Expected value is ~addr_field. With COMPL = 1, addr_field = ~addr, so the expected value is addr.
  - Match: SSR_LOAD pulse with READ = 1 (other fields held). Go to READ.
  - Mismatch, first try: go to CLEAR with retry pending.
  - Mismatch on retry: go to CLEAR with failure flagged.
- **READ:** READ_CYC cycles starting with the read strobe, then go to CLEAR.
- **CLEAR:** one cycle with SSR_CLR = 1 and SSR_DATA = 0, then RESET_CYC-1 quiet cycles.
  - Retry pending: the next cycle is a reload. SSR_LOAD = 1, COMPL = 1, address field = ~addr, stage unchanged. Go back to VERIFY.
  - Otherwise: the next cycle has DONE = 1, BUSY = 0, ERR = failure flag, and the state returns to IDLE.
- **CMD_ABORT** sampled high in VERIFY or READ: go to CLEAR with failure flagged and retry cleared. At most one READ is ever issued per command.
- CMD_REQ while BUSY: ignored, no ACK, not queued.
- Counters are 8-bit and count down. Parameters are constrained to 1..255.

## Timing
Cycle 0 is the ACK/load cycle. V, R and T denote VERIFY_CYC, READ_CYC and RESET_CYC.
- Success path:
  - FB sampled at the end of cycle V.
  - Read strobe in cycle V+1; READ held through cycle V+R.
  - SSR_CLR in cycle V+R+1.
  - DONE in cycle V+R+T+1.
- Retry path:
  - SSR_CLR in cycle V+1.
  - Reload strobe in cycle V+1+T.
  - Second sample at the end of cycle 2V+1+T.
  - The rest follows the success path, offset by V+1+T.
- Retry failure: SSR_CLR in cycle 2V+T+2; DONE with ERR in cycle 2V+2T+2.
- Back-to-back: if CMD_REQ is high in the DONE cycle, the next ACK comes in the following cycle.
- Abort sampled at the end of cycle k: SSR_CLR in cycle k+1, DONE with ERR in cycle k+T+1.

## Test plan
- Defaults, stage 0x3, addr 0x5A, FB = 0xA5 -> ACK cycle 0 with SSR_DATA 0x035A. READ strobe cycle 5 with SSR_DATA 0x135A. CLR cycle 13, DONE cycle 15, ERR 0.
- addr 0x5A, FB = 0x00 then 0x5A -> CLR cycle 5, reload cycle 7 with SSR_DATA 0x23A5, READ cycle 12 with 0x33A5. CLR cycle 20, DONE cycle 22, ERR 0.
- FB stuck at 0x00 -> CLR cycles 5 and 12, no READ bit ever set. DONE and ERR in cycle 14.
- CMD_ABORT in cycle 7 (READ state) -> CLR cycle 8, DONE and ERR in cycle 10. A second CMD_REQ held during BUSY gets no ACK until after DONE.
- SIM_RST asserted in cycle 6 -> SSR_CLR = 1, all other outputs 0. After release, a new request is acknowledged one cycle after it is sampled.
- VERIFY_CYC = READ_CYC = RESET_CYC = 1 -> READ strobe cycle 2, CLR cycle 3, DONE cycle 4.
